// File: rtl/alu_seq_n.sv
// Sequential N-bit ALU: single-cycle add/sub/logic, bit-serial shifts and a
// shift-add multiplier behind a start/busy/done handshake with registered flags.
module alu_seq_n #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         n,
  output logic         z,
  output logic         c,
  output logic         v,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0]  W_OPND  = W'(W);
  localparam logic [CW-1:0] W_CNT   = CW'(W);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SHR = 3'd2;
  localparam logic [2:0] OP_SHL = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } state_e;

  state_e           state_q;
  logic             shl_q;
  logic [W-1:0]     work_q;
  logic [CW-1:0]    cnt_q;
  logic [2*W-1:0]   acc_q;
  logic [2*W-1:0]   mcand_q;
  logic [W-1:0]     mplier_q;
  logic [W-1:0]     y_q;
  logic             n_q, z_q, c_q, v_q, busy_q, done_q;

  logic [W:0]       sum_s;
  logic [W:0]       diff_s;
  logic [W-1:0]     sc_y_s;
  logic             sc_c_s, sc_v_s;
  logic [CW-1:0]    shamt_s;
  logic             multi_s;
  logic [W-1:0]     work_d;
  logic             shout_s;
  logic [2*W-1:0]   acc_d;
  logic [CW-1:0]    cnt_d;
  logic             last_s;
  logic             fin_en_s;
  logic [W-1:0]     fin_y_s;
  logic             fin_c_s, fin_v_s;

  // Single-cycle results straight from the operand inputs (W+1-bit arithmetic)
  always_comb begin
    sum_s  = {1'b0, a} + {1'b0, b};
    diff_s = {1'b0, a} - {1'b0, b};
    sc_y_s = a;
    sc_c_s = 1'b0;
    sc_v_s = 1'b0;
    case (op)
      OP_ADD: begin
        sc_y_s = sum_s[W-1:0];
        sc_c_s = sum_s[W];
        sc_v_s = (a[W-1] == b[W-1]) && (sum_s[W-1] != a[W-1]);
      end
      OP_SUB: begin
        sc_y_s = diff_s[W-1:0];
        sc_c_s = diff_s[W];
        sc_v_s = (a[W-1] != b[W-1]) && (diff_s[W-1] != a[W-1]);
      end
      OP_AND:  sc_y_s = a & b;
      OP_OR:   sc_y_s = a | b;
      OP_XOR:  sc_y_s = a ^ b;
      default: sc_y_s = a;
    endcase
    shamt_s = (b >= W_OPND) ? W_CNT : b[CW-1:0];
    if (op == OP_MUL) begin
      multi_s = 1'b1;
    end else if ((op == OP_SHR) || (op == OP_SHL)) begin
      multi_s = (shamt_s != CNT_ZERO);
    end else begin
      multi_s = 1'b0;
    end
  end

  // One step of the bit-serial shifter and multiplier datapaths
  always_comb begin
    if (shl_q) begin
      work_d  = {work_q[W-2:0], 1'b0};
      shout_s = work_q[W-1];
    end else begin
      work_d  = {1'b0, work_q[W-1:1]};
      shout_s = work_q[0];
    end
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end else begin
      acc_d = acc_q;
    end
    cnt_d  = cnt_q - CNT_ONE;
    last_s = (cnt_q == CNT_ONE);
  end

  // Selects which result, if any, is committed to y and the flags this edge
  always_comb begin
    fin_en_s = 1'b0;
    fin_y_s  = sc_y_s;
    fin_c_s  = sc_c_s;
    fin_v_s  = sc_v_s;
    case (state_q)
      ST_IDLE: begin
        if (start && !multi_s) begin
          fin_en_s = 1'b1;
        end else begin
          fin_en_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (last_s) begin
          fin_en_s = 1'b1;
          fin_y_s  = work_d;
          fin_c_s  = shout_s;
          fin_v_s  = 1'b0;
        end else begin
          fin_en_s = 1'b0;
        end
      end
      ST_MUL: begin
        if (last_s) begin
          fin_en_s = 1'b1;
          fin_y_s  = acc_d[W-1:0];
          fin_c_s  = |acc_d[2*W-1:W];
          fin_v_s  = |acc_d[2*W-1:W];
        end else begin
          fin_en_s = 1'b0;
        end
      end
      default: fin_en_s = 1'b0;
    endcase
  end

  // Control FSM, datapath registers and registered result/flag outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shl_q    <= 1'b0;
      work_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      y_q      <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= fin_en_s;
      if (fin_en_s) begin
        y_q <= fin_y_s;
        n_q <= fin_y_s[W-1];
        z_q <= ~|fin_y_s;
        c_q <= fin_c_s;
        v_q <= fin_v_s;
      end
      case (state_q)
        ST_IDLE: begin
          if (start && multi_s) begin
            busy_q <= 1'b1;
            if (op == OP_MUL) begin
              state_q  <= ST_MUL;
              acc_q    <= '0;
              mcand_q  <= {{W{1'b0}}, a};
              mplier_q <= b;
              cnt_q    <= W_CNT;
            end else begin
              state_q <= ST_SHIFT;
              shl_q   <= (op == OP_SHL);
              work_q  <= a;
              cnt_q   <= shamt_s;
            end
          end
        end
        ST_SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_d;
          if (last_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[2*W-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[W-1:1]};
          cnt_q    <= cnt_d;
          if (last_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign y    = y_q;
  assign n    = n_q;
  assign z    = z_q;
  assign c    = c_q;
  assign v    = v_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_alu_seq_n.sv
// Bench for alu_seq_n (W=8): directed vector table, hand-written handshake and
// reset sequences, then random operations checked against an arithmetic model.
module tb_alu_seq_n;
  localparam int W = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b, y;
  logic         n, z, c, v, busy, done;

  int n_checks = 0;
  int n_fail = 0;

  alu_seq_n #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .y(y), .n(n), .z(z), .c(c), .v(v), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic [3:0] nzcv;
    int         lat;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic definitions; latency counts edges
  // after the capture edge until the edge that raises done.
  function automatic void ref_model(input int fop, input int fa, input int fb,
                                    output int ry, output int rf, output int lat);
    int sa, sb, s, k, full;
    int fc, fv;
    sa = (fa >= (1 << (W - 1))) ? fa - (1 << W) : fa;
    sb = (fb >= (1 << (W - 1))) ? fb - (1 << W) : fb;
    fc = 0; fv = 0; lat = 0; ry = 0;
    k = (fb >= W) ? W : fb;
    case (fop)
      0: begin full = fa + fb; s = sa + sb; ry = full & MASK;
               fc = int'(full > MASK); fv = int'(s > 127 || s < -128); end
      1: begin full = fa - fb; s = sa - sb; ry = full & MASK;
               fc = int'(fa < fb); fv = int'(s > 127 || s < -128); end
      2: begin ry = fa >> k; fc = (k > 0) ? ((fa >> (k - 1)) & 1) : 0; lat = k; end
      3: begin ry = (fa << k) & MASK;
               fc = (k > 0) ? (((fa << (k - 1)) >> (W - 1)) & 1) : 0; lat = k; end
      4: ry = fa & fb;
      5: ry = fa | fb;
      6: ry = fa ^ fb;
      default: begin full = fa * fb; ry = full & MASK;
                     fc = int'(full > MASK); fv = fc; lat = W; end
    endcase
    rf = (int'(ry >= (1 << (W - 1))) << 3) | (int'(ry == 0) << 2) | (fc << 1) | fv;
  endfunction

  // Issues one op at a sampling point, waits (bounded) for done, reports results
  task automatic run_op(input logic [2:0] o, input logic [7:0] oa, input logic [7:0] ob,
                        input bit disturb, output int ry, output int rf,
                        output int lat, output int bcnt);
    op = o; a = oa; b = ob; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (disturb && (lat == 2 || lat == 4)) begin
        start = 1'b1; op = 3'($urandom_range(0, 6));
        a = 8'($urandom); b = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("done_seen", int'(done), 1);
    chk("busy_at_done", int'(busy), 0);
    ry = int'(y);
    rf = int'({n, z, c, v});
  endtask

  initial begin
    int ry, rf, lat, bc, ey, ef, el, dcnt;
    vecs[0]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 4'b1001, 0};
    vecs[1]  = '{3'd1, 8'h03, 8'h05, 8'hFE, 4'b1010, 0};
    vecs[2]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 4'b0110, 0};
    vecs[3]  = '{3'd3, 8'h81, 8'd3,  8'h08, 4'b0000, 3};
    vecs[4]  = '{3'd2, 8'h81, 8'd1,  8'h40, 4'b0010, 1};
    vecs[5]  = '{3'd3, 8'h81, 8'd0,  8'h81, 4'b1000, 0};
    vecs[6]  = '{3'd2, 8'hFF, 8'd200, 8'h00, 4'b0110, 8};
    vecs[7]  = '{3'd7, 8'h0F, 8'h0F, 8'hE1, 4'b1000, 8};
    vecs[8]  = '{3'd7, 8'h10, 8'h10, 8'h00, 4'b0111, 8};
    vecs[9]  = '{3'd4, 8'hF0, 8'h3C, 8'h30, 4'b0000, 0};
    vecs[10] = '{3'd5, 8'h0F, 8'h80, 8'h8F, 4'b1000, 0};
    vecs[11] = '{3'd6, 8'hAA, 8'hAA, 8'h00, 4'b0100, 0};
    vecs[12] = '{3'd1, 8'h80, 8'h01, 8'h7F, 4'b0001, 0};
    vecs[13] = '{3'd3, 8'h01, 8'd8,  8'h00, 4'b0110, 8};

    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00;
    #12;
    chk("reset_outputs", int'({y, n, z, c, v, busy, done}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, ry, rf, lat, bc);
      chk($sformatf("vec%0d_y", i), ry, int'(vecs[i].y));
      chk($sformatf("vec%0d_nzcv", i), rf, int'(vecs[i].nzcv));
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].lat);
    end

    // done is a single-cycle pulse and results hold afterwards
    @(posedge clk); #1;
    chk("done_pulse_width", int'(done), 0);
    chk("hold_y", int'(y), 8'h00);
    chk("hold_flags", int'({n, z, c, v}), 4'b0110);

    // Disturbed multiply, then a multiply started on the done cycle
    run_op(3'd7, 8'h0F, 8'h0F, 1'b1, ry, rf, lat, bc);
    chk("mul_disturb_y", ry, 8'hE1);
    chk("mul_disturb_flags", rf, 4'b1000);
    chk("mul_disturb_latency", lat, 8);
    run_op(3'd7, 8'h03, 8'h05, 1'b0, ry, rf, lat, bc);
    chk("b2b_mul_y", ry, 8'h0F);
    chk("b2b_mul_busy_cycles", bc, 8);

    // Asynchronous reset in the 4th cycle of a multiply
    op = 3'd7; a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", int'({y, n, z, c, v, busy, done}), 0);
    #8 rst_n = 1'b1;
    dcnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    chk("no_done_after_reset", dcnt, 0);
    run_op(3'd0, 8'h05, 8'h07, 1'b0, ry, rf, lat, bc);
    chk("post_reset_add_y", ry, 8'h0C);
    chk("post_reset_add_latency", lat, 0);

    // Random operations against the reference model
    for (int i = 0; i < 60; i++) begin
      int ro, ra, rb;
      ro = $urandom_range(0, 7);
      ra = $urandom_range(0, MASK);
      if ((ro == 2 || ro == 3) && $urandom_range(0, 3) != 0) rb = $urandom_range(0, 9);
      else rb = $urandom_range(0, MASK);
      ref_model(ro, ra, rb, ey, ef, el);
      run_op(3'(ro), 8'(ra), 8'(rb), 1'b0, ry, rf, lat, bc);
      chk($sformatf("rnd%0d_op%0d_y", i, ro), ry, ey);
      chk($sformatf("rnd%0d_op%0d_nzcv", i, ro), rf, ef);
      chk($sformatf("rnd%0d_op%0d_latency", i, ro), lat, el);
      chk($sformatf("rnd%0d_op%0d_busy_cycles", i, ro), bc, el);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
